uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter CLK_FRE, default 27, clock frequency in MHz.
REQ-002 Parameter TIMEOUT_US, default 1000, inter-byte timeout in microseconds; TIMEOUT_CYC = CLK_FRE*TIMEOUT_US.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_data_valid  input  1  rx_data holds a new byte.
REQ-008 rx_data_ready  output  1  parser accepts a byte this cycle.
REQ-009 cmd_addr  output  8  decoded register address.
REQ-010 cmd_wdata  output  16  decoded write data, {DATA_H, DATA_L}.
REQ-011 cmd_valid  output  1  command presented on cmd_addr/cmd_wdata.
REQ-012 cmd_ready  input  1  consumer accepts the command.
REQ-013 err_chk  output  1  one-cycle pulse on checksum mismatch.
REQ-014 err_timeout  output  1  one-cycle pulse on inter-byte timeout.
REQ-015 frame_cnt  output  8  count of accepted good frames.

Function
REQ-016 Frame format SHALL be 5 bytes: SYNC_BYTE, ADDR, DATA_H, DATA_L, CHK, with CHK = ADDR ^ DATA_H ^ DATA_L.
REQ-017 A byte SHALL be consumed only on a cycle with rx_data_valid && rx_data_ready.
REQ-018 rx_data_ready SHALL be a combinational function of state: 1 in S_SYNC, S_ADDR, S_DH, S_DL, S_CHK; 0 in S_OUT.
REQ-019 FSM states SHALL be S_SYNC, S_ADDR, S_DH, S_DL, S_CHK, S_OUT.
REQ-020 S_SYNC: a consumed byte equal to SYNC_BYTE -> S_ADDR; any other byte is discarded silently and the FSM stays in S_SYNC.
REQ-021 S_ADDR/S_DH/S_DL: a consumed byte is stored and the FSM advances to the next state; SYNC_BYTE is treated as ordinary data in these states.
REQ-022 S_CHK: a consumed byte equal to the running XOR -> load cmd_addr/cmd_wdata, go to S_OUT, and set cmd_valid=1 on the next cycle.
REQ-023 S_CHK: on a checksum mismatch, pulse err_chk for exactly one cycle, go to S_SYNC, and do not change cmd_* outputs.
REQ-024 S_OUT: cmd_valid SHALL hold at 1 and cmd_addr/cmd_wdata SHALL stay stable until cmd_ready=1.
REQ-025 On the cycle cmd_valid && cmd_ready, the FSM SHALL go to S_SYNC, cmd_valid SHALL clear next cycle, and frame_cnt SHALL increment, wrapping 255 -> 0.
REQ-026 The timeout counter SHALL be 32 bits wide.
REQ-027 The timeout counter SHALL clear on every consumed byte and whenever the FSM is in S_SYNC or S_OUT, and SHALL otherwise increment.
REQ-028 When the counter reaches TIMEOUT_CYC-1 in S_ADDR..S_CHK, err_timeout SHALL pulse for one cycle and the FSM SHALL go to S_SYNC, discarding the partial frame.
REQ-029 If a byte is consumed on the same cycle the counter reaches TIMEOUT_CYC-1, the byte SHALL win: no timeout, normal transition.
REQ-030 err_chk and err_timeout SHALL never assert on the same cycle.
REQ-031 Latency from consuming the CHK byte to cmd_valid=1 SHALL be 1 cycle.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state S_SYNC, cmd_valid=0, cmd_addr=0, cmd_wdata=0, err_chk=0, err_timeout=0, frame_cnt=0, timeout counter=0, and the stored bytes and running XOR to 0.
REQ-033 After reset, rx_data_ready SHALL be 1, because state is S_SYNC.
REQ-034 Reset asserted mid-frame or during S_OUT SHALL discard the frame with no cmd_valid and no error pulse.

Verification
REQ-035 Bytes A5,12,34,56,70 (0x12^0x34^0x56=0x70) -> cmd_valid=1 one cycle after the 5th byte; cmd_addr=12, cmd_wdata=3456; with cmd_ready=1, frame_cnt goes 0 -> 1.
REQ-036 Bytes A5,12,34,56,71 -> err_chk pulses for 1 cycle, cmd_valid stays 0, FSM back in S_SYNC; then a following valid frame is decoded correctly.
REQ-037 Bytes 00,FF,A5,01,00,02,03 -> leading 00 and FF are ignored; command addr=01, wdata=0002.
REQ-038 A5,01 then idle for TIMEOUT_CYC cycles -> err_timeout pulses once, then A5,01,00,02,03 decodes normally; a byte arriving exactly at count TIMEOUT_CYC-1 gives no timeout.
REQ-039 Valid frame with cmd_ready held 0 for 20 cycles -> cmd_valid and data stable, rx_data_ready=0 throughout; sending 256 good frames returns frame_cnt to 0.
REQ-040 Reset pulsed after A5,12,34 -> all outputs at reset values; the remaining bytes 56,70 produce no command.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// Byte stream in, decoded command out, plus status: everything the frame
// parser exchanges with its neighbours apart from clock and reset.
interface uart_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err_chk;
  logic        err_timeout;
  logic [7:0]  frame_cnt;

  modport master (
    output rx_data, rx_data_valid, cmd_ready,
    input  rx_data_ready, cmd_addr, cmd_wdata, cmd_valid,
           err_chk, err_timeout, frame_cnt
  );

  modport slave (
    input  rx_data, rx_data_valid, cmd_ready,
    output rx_data_ready, cmd_addr, cmd_wdata, cmd_valid,
           err_chk, err_timeout, frame_cnt
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SYNC/ADDR/DATA_H/DATA_L/CHK byte frames into register-write commands,
// with XOR checksum checking and an inter-byte timeout that drops partial frames.
module uart_frame_parser #(
  parameter int         CLK_FRE    = 27,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input logic                clk,
  input logic                rst_n,
  uart_frame_parser_if.slave bus
);

  localparam logic [31:0] TIMEOUT_CYC  = 32'(CLK_FRE * TIMEOUT_US);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;

  typedef enum logic [2:0] {S_SYNC, S_ADDR, S_DH, S_DL, S_CHK, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, dh_q, dl_q, xor_q;
  logic [31:0] cnt_q;
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_wdata_q;
  logic        cmd_valid_q, err_chk_q, err_timeout_q;
  logic [7:0]  frame_cnt_q;

  logic rx_ready, consume, in_frame, timeout_hit;
  logic chk_ok, chk_bad, cmd_done;

  assign rx_ready    = (state_q != S_OUT);
  assign consume     = bus.rx_data_valid && rx_ready;
  assign in_frame    = (state_q == S_ADDR) || (state_q == S_DH) ||
                       (state_q == S_DL)   || (state_q == S_CHK);
  // A byte arriving on the last allowed cycle beats the timeout.
  assign timeout_hit = in_frame && !consume && (cnt_q == TIMEOUT_LAST);

  assign bus.rx_data_ready = rx_ready;
  assign bus.cmd_addr      = cmd_addr_q;
  assign bus.cmd_wdata     = cmd_wdata_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.err_chk       = err_chk_q;
  assign bus.err_timeout   = err_timeout_q;
  assign bus.frame_cnt     = frame_cnt_q;

  always_comb begin
    state_d  = state_q;
    chk_ok   = 1'b0;
    chk_bad  = 1'b0;
    cmd_done = 1'b0;
    if (timeout_hit) begin
      state_d = S_SYNC;
    end else begin
      unique case (state_q)
        S_SYNC: if (consume && bus.rx_data == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: if (consume) state_d = S_DH;
        S_DH:   if (consume) state_d = S_DL;
        S_DL:   if (consume) state_d = S_CHK;
        S_CHK: begin
          if (consume) begin
            if (bus.rx_data == xor_q) begin
              chk_ok  = 1'b1;
              state_d = S_OUT;
            end else begin
              chk_bad = 1'b1;
              state_d = S_SYNC;
            end
          end
        end
        S_OUT: begin
          if (cmd_valid_q && bus.cmd_ready) begin
            cmd_done = 1'b1;
            state_d  = S_SYNC;
          end
        end
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SYNC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      dh_q          <= '0;
      dl_q          <= '0;
      xor_q         <= '0;
      cnt_q         <= '0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_valid_q   <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      if (consume || !in_frame) cnt_q <= '0;
      else                      cnt_q <= cnt_q + 32'd1;

      if (consume) begin
        unique case (state_q)
          S_ADDR: begin
            addr_q <= bus.rx_data;
            xor_q  <= bus.rx_data;
          end
          S_DH: begin
            dh_q  <= bus.rx_data;
            xor_q <= xor_q ^ bus.rx_data;
          end
          S_DL: begin
            dl_q  <= bus.rx_data;
            xor_q <= xor_q ^ bus.rx_data;
          end
          default: ;
        endcase
      end

      err_chk_q     <= chk_bad;
      err_timeout_q <= timeout_hit;

      if (chk_ok) begin
        cmd_addr_q  <= addr_q;
        cmd_wdata_q <= {dh_q, dl_q};
        cmd_valid_q <= 1'b1;
      end else if (cmd_done) begin
        cmd_valid_q <= 1'b0;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: fixed vector table, directed corner
// sequences and randomized frame streams compared against a byte-queue model.
module tb_uart_frame_parser;

  localparam int         T    = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .CLK_FRE    (1),
    .TIMEOUT_US (T),
    .SYNC_BYTE  (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bytes collected since SYNC, plus a held command.
  bit          m_hold;
  bit          m_in_frame;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [7:0]  m_fc;
  bit          m_err_chk;
  bit          m_err_to;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        cmd_ready;
    logic        exp_cv;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_ec;
    logic        exp_et;
    logic [7:0]  exp_fc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_in_frame = 0; m_bytes.delete(); m_idle = 0;
    m_addr = '0; m_wdata = '0; m_fc = '0; m_err_chk = 0; m_err_to = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    m_err_chk = 0;
    m_err_to  = 0;
    if (m_hold) begin
      if (r) begin
        m_hold = 0;
        m_fc   = m_fc + 8'd1;
      end
      m_idle = 0;
    end else if (!m_in_frame) begin
      m_idle = 0;
      if (v && d == SYNC) begin
        m_in_frame = 1;
        m_bytes.delete();
      end
    end else if (v) begin
      m_idle = 0;
      if (m_bytes.size() < 3) begin
        m_bytes.push_back(d);
      end else begin
        m_in_frame = 0;
        if (d == (m_bytes[0] ^ m_bytes[1] ^ m_bytes[2])) begin
          m_addr  = m_bytes[0];
          m_wdata = {m_bytes[1], m_bytes[2]};
          m_hold  = 1;
        end else begin
          m_err_chk = 1;
        end
      end
    end else if (m_idle == T - 1) begin
      m_err_to   = 1;
      m_in_frame = 0;
      m_idle     = 0;
    end else begin
      m_idle++;
    end
  endtask

  task automatic check_output();
    check("cmd_valid",   32'(bus.cmd_valid),   32'(m_hold));
    check("cmd_addr",    32'(bus.cmd_addr),    32'(m_addr));
    check("cmd_wdata",   32'(bus.cmd_wdata),   32'(m_wdata));
    check("err_chk",     32'(bus.err_chk),     32'(m_err_chk));
    check("err_timeout", 32'(bus.err_timeout), 32'(m_err_to));
    check("frame_cnt",   32'(bus.frame_cnt),   32'(m_fc));
  endtask

  // One clock of stimulus: ready is checked before the edge, outputs after it.
  task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic r);
    bus.rx_data_valid = v;
    bus.rx_data       = d;
    bus.cmd_ready     = r;
    #1;
    check("rx_data_ready", 32'(bus.rx_data_ready), 32'(!m_hold));
    model_step(v, d, r);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic do_reset();
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    bus.cmd_ready     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cmd_valid",   32'(bus.cmd_valid),     32'd0);
    check("rst_cmd_addr",    32'(bus.cmd_addr),      32'd0);
    check("rst_cmd_wdata",   32'(bus.cmd_wdata),     32'd0);
    check("rst_err_chk",     32'(bus.err_chk),       32'd0);
    check("rst_err_timeout", 32'(bus.err_timeout),   32'd0);
    check("rst_frame_cnt",   32'(bus.frame_cnt),     32'd0);
    check("rst_ready",       32'(bus.rx_data_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(input logic v, input logic [7:0] d, input logic r,
                                  input logic cv, input logic [7:0] a, input logic [15:0] w,
                                  input logic ec, input logic et, input logic [7:0] fc);
    vec_t x;
    x.valid = v; x.data = d; x.cmd_ready = r;
    x.exp_cv = cv; x.exp_addr = a; x.exp_wdata = w;
    x.exp_ec = ec; x.exp_et = et; x.exp_fc = fc;
    vecs.push_back(x);
  endfunction

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit taken;
    int tries;
    for (int i = 0; i < gap; i++)
      apply_stimulus(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
    taken = 0;
    tries = 0;
    while (!taken && tries < 200) begin
      taken = !m_hold;
      apply_stimulus(1'b1, d, 1'($urandom_range(0, 1)));
      tries++;
    end
    check("byte_accepted", 32'(taken), 32'd1);
  endtask

  task automatic send_good_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                                 input logic r);
    apply_stimulus(1'b1, SYNC, r);
    apply_stimulus(1'b1, a, r);
    apply_stimulus(1'b1, h, r);
    apply_stimulus(1'b1, l, r);
    apply_stimulus(1'b1, a ^ h ^ l, r);
  endtask

  initial begin
    logic [7:0]  fc_start;
    logic [7:0]  a, h, l, c;
    int          gap;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bus.rx_data_valid = 1'b0;
    bus.rx_data       = 8'h00;
    bus.cmd_ready     = 1'b0;
    #3;
    do_reset();

    // Good frame, bad checksum followed by a good frame, leading junk bytes.
    add_vec(1, 8'hA5, 1, 0, 8'h00, 16'h0000, 0, 0, 8'd0);
    add_vec(1, 8'h12, 1, 0, 8'h00, 16'h0000, 0, 0, 8'd0);
    add_vec(1, 8'h34, 1, 0, 8'h00, 16'h0000, 0, 0, 8'd0);
    add_vec(1, 8'h56, 1, 0, 8'h00, 16'h0000, 0, 0, 8'd0);
    add_vec(1, 8'h70, 1, 1, 8'h12, 16'h3456, 0, 0, 8'd0);
    add_vec(0, 8'h00, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'hA5, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h12, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h34, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h56, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h71, 1, 0, 8'h12, 16'h3456, 1, 0, 8'd1);
    add_vec(0, 8'h00, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'hA5, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h0A, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h0B, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h0C, 1, 0, 8'h12, 16'h3456, 0, 0, 8'd1);
    add_vec(1, 8'h0D, 1, 1, 8'h0A, 16'h0B0C, 0, 0, 8'd1);
    add_vec(0, 8'h00, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'h00, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'hFF, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'hA5, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'h01, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'h00, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'h02, 1, 0, 8'h0A, 16'h0B0C, 0, 0, 8'd2);
    add_vec(1, 8'h03, 1, 1, 8'h01, 16'h0002, 0, 0, 8'd2);
    add_vec(0, 8'h00, 1, 0, 8'h01, 16'h0002, 0, 0, 8'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].data, vecs[i].cmd_ready);
      check("vec_cmd_valid",   32'(bus.cmd_valid),   32'(vecs[i].exp_cv));
      check("vec_cmd_addr",    32'(bus.cmd_addr),    32'(vecs[i].exp_addr));
      check("vec_cmd_wdata",   32'(bus.cmd_wdata),   32'(vecs[i].exp_wdata));
      check("vec_err_chk",     32'(bus.err_chk),     32'(vecs[i].exp_ec));
      check("vec_err_timeout", 32'(bus.err_timeout), 32'(vecs[i].exp_et));
      check("vec_frame_cnt",   32'(bus.frame_cnt),   32'(vecs[i].exp_fc));
    end

    // Timeout after a partial frame, then a normal frame decodes.
    apply_stimulus(1'b1, SYNC, 1'b1);
    apply_stimulus(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < T - 1; i++) apply_stimulus(1'b0, 8'h00, 1'b1);
    check("timeout_quiet", 32'(bus.err_timeout), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("timeout_pulse", 32'(bus.err_timeout), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("timeout_single", 32'(bus.err_timeout), 32'd0);
    send_good_frame(8'h01, 8'h00, 8'h02, 1'b1);
    check("after_to_valid", 32'(bus.cmd_valid), 32'd1);
    check("after_to_wdata", 32'(bus.cmd_wdata), 32'h0002);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    // Byte arriving on the last allowed cycle wins over the timeout.
    apply_stimulus(1'b1, SYNC, 1'b1);
    for (int i = 0; i < T - 1; i++) apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b1, 8'h01, 1'b1);
    check("edge_no_timeout", 32'(bus.err_timeout), 32'd0);
    apply_stimulus(1'b1, 8'h00, 1'b1);
    apply_stimulus(1'b1, 8'h02, 1'b1);
    apply_stimulus(1'b1, 8'h03, 1'b1);
    check("edge_cmd_valid", 32'(bus.cmd_valid), 32'd1);
    check("edge_cmd_addr",  32'(bus.cmd_addr),  32'h01);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    // Backpressure: command held stable and no bytes accepted.
    send_good_frame(8'h21, 8'h43, 8'h65, 1'b0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, SYNC, 1'b0);
      check("bp_valid", 32'(bus.cmd_valid),     32'd1);
      check("bp_addr",  32'(bus.cmd_addr),      32'h21);
      check("bp_wdata", 32'(bus.cmd_wdata),     32'h4365);
      check("bp_ready", 32'(bus.rx_data_ready), 32'd0);
    end
    fc_start = m_fc;
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check("bp_release", 32'(bus.frame_cnt), 32'(fc_start + 8'd1));

    // 256 good frames bring frame_cnt back to where it started.
    fc_start = m_fc;
    for (int i = 0; i < 256; i++) begin
      send_good_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      apply_stimulus(1'b0, 8'h00, 1'b1);
    end
    check("frame_cnt_wrap", 32'(bus.frame_cnt), 32'(fc_start));

    // Reset mid-frame: the remaining bytes produce no command.
    apply_stimulus(1'b1, SYNC, 1'b1);
    apply_stimulus(1'b1, 8'h12, 1'b1);
    apply_stimulus(1'b1, 8'h34, 1'b1);
    do_reset();
    apply_stimulus(1'b1, 8'h56, 1'b1);
    apply_stimulus(1'b1, 8'h70, 1'b1);
    check("midrst_no_cmd", 32'(bus.cmd_valid), 32'd0);
    check("midrst_no_err", 32'(bus.err_chk),   32'd0);

    // Reset while a command is held.
    send_good_frame(8'h33, 8'h44, 8'h55, 1'b0);
    check("out_before_rst", 32'(bus.cmd_valid), 32'd1);
    do_reset();
    apply_stimulus(1'b0, 8'h00, 1'b1);

    // Randomized frame stream with junk, bad checksums and long gaps.
    for (int f = 0; f < 150; f++) begin
      for (int j = 0; j < $urandom_range(0, 2); j++) send_byte(8'($urandom), 0);
      a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
      c = ($urandom_range(0, 4) == 0) ? (a ^ h ^ l ^ 8'h5A) : (a ^ h ^ l);
      gap = ($urandom_range(0, 19) == 0) ? T + 3 : $urandom_range(0, 2);
      send_byte(SYNC, $urandom_range(0, 2));
      send_byte(a, $urandom_range(0, 2));
      send_byte(h, gap);
      send_byte(l, $urandom_range(0, 2));
      send_byte(c, $urandom_range(0, 2));
    end
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
